// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg -- shared types and constants for the mem_responder slice.
//   state_e     : responder FSM states (IDLE/BUSY/RESP/DONE)
//   op_e        : latched request kind (read/write)
//   LINE_W      : default line width in bits
//   ADDR_W      : default line address width
//   LFSR_SEED   : reset value of the random-latency LFSR
//   LFSR_TAPS   : tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   lfsr8_next(): one Fibonacci step of that LFSR
package mem_resp_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Shift left, feedback is the XOR of the tapped bits.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
    lfsr8_next = {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_resp_lfsr8.sv
// mem_resp_lfsr8 -- free-running 8-bit LFSR used to jitter the response
// latency. Only instantiated when MEM_RESP_RAND_LAT_EN is defined.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset (loads LFSR_SEED)
//   lfsr_o out current LFSR state, advances every cycle
module mem_resp_lfsr8
  import mem_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;

  // LFSR state register, stepped every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr8_next(lfsr_q);
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder -- memory-side responder for the cache's line interface.
// Accepts a line read or write, waits a programmable latency, then pulses
// mem_ready for one cycle. Requests are backed by an inline line store
// indexed by mem_addr[IDX_W-1:0]; upper address bits alias (no tag check).
// Also flags protocol violations (dropped request, address change while
// busy, simultaneous read+write) on the sticky err_proto output.
// Optional build macro: MEM_RESP_RAND_LAT_EN adds 0..7 cycles of LFSR
// driven extra latency per request.
// Ports:
//   clk           in  clock, rising edge
//   proc_reset_n  in  asynchronous active-low reset
//   mem_read      in  line read request, held until mem_ready
//   mem_write     in  line write request, held until mem_ready
//   mem_addr      in  line address
//   mem_wdata     in  write line data
//   mem_ready     out one-cycle completion pulse
//   mem_rdata     out read line data (registered, held until next read)
//   err_proto     out sticky protocol-violation flag
//   rd_cnt        out completed reads, saturating
//   wr_cnt        out completed writes, saturating
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int LINE_W  = mem_resp_pkg::LINE_W,
  parameter int ADDR_W  = mem_resp_pkg::ADDR_W,
  parameter int IDX_W   = 6,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              err_proto,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int DEPTH = 1 << IDX_W;
  // Wide enough for LATENCY (<=255) plus the optional 0..7 jitter.
  localparam int LAT_W = 9;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic               ready_q, ready_d;
  logic [LINE_W-1:0]  rdata_q, rdata_d;
  logic [LINE_W-1:0]  store_q [DEPTH];
  logic [LAT_W-1:0]   lat_eff_s;
  logic               held_s;

`ifdef MEM_RESP_RAND_LAT_EN
  logic [7:0] lfsr_s;

  mem_resp_lfsr8 u_lfsr (
    .clk    (clk),
    .rst_n  (proc_reset_n),
    .lfsr_o (lfsr_s)
  );

  assign lat_eff_s = LAT_W'(LATENCY) + {{(LAT_W-3){1'b0}}, lfsr_s[2:0]};
`else
  assign lat_eff_s = LAT_W'(LATENCY);
`endif

  // The request line that must stay high is the one of the latched op.
  assign held_s = (op_q == OP_WRITE) ? mem_write : mem_read;

  // Next-state, request latching, error and counter logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          op_d    = mem_write ? OP_WRITE : OP_READ;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          if (mem_read && mem_write) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          // BUSY lasts lat-1 cycles; cnt counts the remaining ones down to 0.
          if (lat_eff_s == LAT_W'(1)) begin
            state_d = ST_RESP;
            cnt_d   = '0;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = lat_eff_s - LAT_W'(2);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!held_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          if (mem_addr != addr_q) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (cnt_q == '0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = cnt_q - LAT_W'(1);
          end
        end
      end
      ST_RESP: begin
        state_d = ST_DONE;
        if (op_q == OP_WRITE) begin
          if (wr_cnt_q != {CNT_W{1'b1}}) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end else begin
            wr_cnt_d = wr_cnt_q;
          end
        end else begin
          if (rd_cnt_q != {CNT_W{1'b1}}) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end else begin
            rd_cnt_d = rd_cnt_q;
          end
        end
      end
      ST_DONE: begin
        // Requester drops its request this cycle; anything still high is
        // picked up again from IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs: ready and read data are set on entry to RESP.
  // Using addr_d/op_d covers both the BUSY->RESP and IDLE->RESP paths.
  always_comb begin
    ready_d = (state_d == ST_RESP);
    if ((state_d == ST_RESP) && (op_d == OP_READ)) begin
      rdata_d = store_q[addr_d[IDX_W-1:0]];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
    end
  end

  // Line store: not reset; a write commits at the end of its RESP cycle.
  always_ff @(posedge clk) begin
    if ((state_q == ST_RESP) && (op_q == OP_WRITE)) begin
      store_q[addr_q[IDX_W-1:0]] <= wdata_q;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign err_proto = err_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- directed self-checking bench for mem_responder.
// Instance A: LATENCY=4, 16-bit counters (write/read, alias, address
// change, reset, abort, simultaneous read+write).
// Instance B: LATENCY=1, 2-bit counters (latency floor, back-to-back
// spacing, counter saturation).
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         a_read, a_write, a_ready, a_err;
  logic [27:0]  a_addr;
  logic [127:0] a_wdata, a_rdata;
  logic [15:0]  a_rd_cnt, a_wr_cnt;

  logic         b_read, b_write, b_ready, b_err;
  logic [27:0]  b_addr;
  logic [127:0] b_wdata, b_rdata;
  logic [1:0]   b_rd_cnt, b_wr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] D1   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2   = 128'hDEADBEEF00000000CAFEF00D12345678;
  localparam logic [127:0] ONES = {128{1'b1}};

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(4), .CNT_W(16)) u_dut_a (
    .clk          (clk),
    .proc_reset_n (rst_n),
    .mem_read     (a_read),
    .mem_write    (a_write),
    .mem_addr     (a_addr),
    .mem_wdata    (a_wdata),
    .mem_ready    (a_ready),
    .mem_rdata    (a_rdata),
    .err_proto    (a_err),
    .rd_cnt       (a_rd_cnt),
    .wr_cnt       (a_wr_cnt)
  );

  mem_responder #(.LATENCY(1), .CNT_W(2)) u_dut_b (
    .clk          (clk),
    .proc_reset_n (rst_n),
    .mem_read     (b_read),
    .mem_write    (b_write),
    .mem_addr     (b_addr),
    .mem_wdata    (b_wdata),
    .mem_ready    (b_ready),
    .mem_rdata    (b_rdata),
    .err_proto    (b_err),
    .rd_cnt       (b_rd_cnt),
    .wr_cnt       (b_wr_cnt)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Issue a request on A from an IDLE cycle, expect ready 4 cycles later,
  // drop the request in the DONE cycle and return in the following IDLE.
  task automatic do_req(input logic rd, input logic wr, input logic [27:0] addr,
                        input logic [127:0] wd, input string tag,
                        output logic [127:0] rdata_rdy);
    int n;
    a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd;
    n = 0;
    do begin
      step();
      n++;
    end while (a_ready !== 1'b1 && n < 20);
    check_eq({tag, "_lat"}, 128'(n), 128'd4);
    rdata_rdy = a_rdata;
    step();
    check_eq({tag, "_pulse"}, {127'd0, a_ready}, 128'd0);
    a_read = 1'b0; a_write = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rd_v;
    int exp_cnt;
    a_read = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;

    // Reset state
    step();
    check_eq("rst_ready", {127'd0, a_ready}, 128'd0);
    check_eq("rst_rdata", a_rdata, 128'd0);
    check_eq("rst_err",   {127'd0, a_err}, 128'd0);
    check_eq("rst_rdcnt", 128'(a_rd_cnt), 128'd0);
    check_eq("rst_wrcnt", 128'(a_wr_cnt), 128'd0);
    check_eq("rst_b_cnt", 128'(b_rd_cnt), 128'd0);
    step();
    rst_n = 1'b1;
    step();

    // Write then read back address 3
    do_req(1'b0, 1'b1, 28'h0000003, D1, "wr3", rd_v);
    check_eq("wr3_wrcnt", 128'(a_wr_cnt), 128'd1);
    check_eq("wr3_rdcnt", 128'(a_rd_cnt), 128'd0);
    check_eq("wr3_err",   {127'd0, a_err}, 128'd0);
    do_req(1'b1, 1'b0, 28'h0000003, '0, "rd3", rd_v);
    check_eq("rd3_data",  rd_v, D1);
    check_eq("rd3_hold",  a_rdata, D1);
    check_eq("rd3_rdcnt", 128'(a_rd_cnt), 128'd1);

    // Upper address bits alias onto the same line
    do_req(1'b1, 1'b0, 28'h0000043, '0, "alias", rd_v);
    check_eq("alias_data",  rd_v, D1);
    check_eq("alias_rdcnt", 128'(a_rd_cnt), 128'd2);
    check_eq("alias_err",   {127'd0, a_err}, 128'd0);

    // Address change during BUSY: latched address wins, error flagged
    a_read = 1'b1; a_addr = 28'h0000003;
    step(); step();
    a_addr = 28'h0000010;
    step();
    check_eq("chg_rdy3", {127'd0, a_ready}, 128'd0);
    step();
    check_eq("chg_rdy4", {127'd0, a_ready}, 128'd1);
    check_eq("chg_data", a_rdata, D1);
    step();
    a_read = 1'b0;
    check_eq("chg_err", {127'd0, a_err}, 128'd1);
    step();

    // Reset in the middle of a read
    a_read = 1'b1; a_addr = 28'h0000003;
    step(); step();
    rst_n = 1'b0;
    #1;
    check_eq("mrst_ready", {127'd0, a_ready}, 128'd0);
    check_eq("mrst_rdata", a_rdata, 128'd0);
    check_eq("mrst_err",   {127'd0, a_err}, 128'd0);
    check_eq("mrst_rdcnt", 128'(a_rd_cnt), 128'd0);
    check_eq("mrst_wrcnt", 128'(a_wr_cnt), 128'd0);
    a_read = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    check_eq("mrst_noready", {127'd0, a_ready}, 128'd0);
    do_req(1'b1, 1'b0, 28'h0000003, '0, "post_rst", rd_v);
    check_eq("post_rst_data",  rd_v, D1);
    check_eq("post_rst_rdcnt", 128'(a_rd_cnt), 128'd1);

    // Abort: write dropped at C0+2
    a_write = 1'b1; a_addr = 28'h0000003; a_wdata = D2;
    step(); step();
    a_write = 1'b0;
    step();
    check_eq("abort_ready", {127'd0, a_ready}, 128'd0);
    check_eq("abort_err",   {127'd0, a_err}, 128'd1);
    do_req(1'b1, 1'b0, 28'h0000003, '0, "abort_rd", rd_v);
    check_eq("abort_line",  rd_v, D1);
    check_eq("abort_wrcnt", 128'(a_wr_cnt), 128'd0);

    // Simultaneous read+write: write wins, error flagged
    do_reset();
    do_req(1'b1, 1'b1, 28'h0000005, ONES, "both", rd_v);
    check_eq("both_wrcnt", 128'(a_wr_cnt), 128'd1);
    check_eq("both_rdcnt", 128'(a_rd_cnt), 128'd0);
    check_eq("both_err",   {127'd0, a_err}, 128'd1);
    do_req(1'b1, 1'b0, 28'h0000005, '0, "both_rd", rd_v);
    check_eq("both_rd_data", rd_v, ONES);

    // Instance B: LATENCY=1, request held -> ready every 3 cycles,
    // 2-bit read counter saturates at 3.
    b_read = 1'b1; b_addr = 28'h0000000;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      step();
      exp_cnt = (cyc + 1) / 3;
      if (exp_cnt > 3) exp_cnt = 3;
      check_eq($sformatf("b_rdy_%0d", cyc), {127'd0, b_ready},
               (cyc % 3 == 1) ? 128'd1 : 128'd0);
      check_eq($sformatf("b_cnt_%0d", cyc), 128'(b_rd_cnt), 128'(exp_cnt));
    end
    b_read = 1'b0;
    check_eq("b_err", {127'd0, b_err}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
